fpcvt_sched: RTL and testbench
==============================

Name: fpcvt_sched

Overview:
- Round-robin scheduler and sequencer for one shared 12-bit two's-complement to 8-bit floating-point conversion datapath.
- Accepts samples from N_REQ requesters and grants one at a time.
- Runs the conversion as a multi-cycle sequence: absolute value, iterative one-bit-per-cycle normalisation, then rounding.
- Returns {sign, exp, frac} tagged with the requester id over a valid/ready handshake; the result value is frac * 2^exp.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of out_id; 2^ID_W >= N_REQ.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester sample valid; once raised, held until accepted.
- req_ready  out  N_REQ  per-requester accept strobe.
- req_data  in  12*N_REQ  requester i sample at [12*i+11:12*i], two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_id  out  ID_W  index of the requester that owns the result.
- out_sign  out  1  sign of the result.
- out_exp  out  3  exponent.
- out_frac  out  4  significand.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; out_valid, out_id, out_sign, out_exp, out_frac and busy go to 0; rr_ptr goes to N_REQ-1.
  - Any in-flight conversion is dropped with no result.
  - req_ready reads 0 during reset.
- States: IDLE, LOAD, NORM, ROUND, RESP.
- IDLE:
  - Grant the first requester with req_valid set, searching from rr_ptr+1 modulo N_REQ upward.
  - req_ready[g] is combinational: it is 1 only in IDLE, only for the granted index, and only while its req_valid is 1. At most one bit is ever set.
  - On that cycle: capture req_data[g] and g, set rr_ptr to g, go to LOAD.
  - No req_valid set: stay in IDLE.
- LOAD:
  - sign = D[11].
  - mag = |D| as 12 bits; D = -2048 saturates to mag = 2047.
  - Load shift register m = mag[10:0] and e = 7. Go to NORM.
- NORM (once per cycle):
  - If e == 0 or m[10] == 1, go to ROUND.
  - Otherwise shift m left by 1 and decrement e.
  - NORM occupancy is min(lz-1, 7) + 1 cycles, where lz is the leading-zero count of the 12-bit mag.
- ROUND:
  - f = m[10:7] and r = m[6]; if r == 1, f = f + 1.
  - If f overflows to 16: f = 8 and e = e + 1.
  - If e would exceed 7: e = 7 and f = 15 (saturation).
  - Register out_sign, out_exp, out_frac and out_id, set out_valid = 1, go to RESP.
- RESP:
  - out_valid and all out_* fields stay stable until out_ready is 1.
  - out_valid && out_ready: clear out_valid next cycle and go to IDLE.
  - No request is accepted in RESP, so there is a one-cycle bubble in IDLE before the next grant.
- Latency (accept cycle = 0):
  - out_valid rises at cycle 3 + NORM occupancy.
  - Minimum is 4 (|D| >= 1024); maximum is 11 (|D| < 16).
- Zero input gives sign 0, exp 0, frac 0.
- Requesters not granted keep req_valid asserted and lose nothing. A requester dropping req_valid before acceptance is legal and simply not served.

Test Plan:
- Single requester 0 with D = 422 (0x1A6) -> sign 0, exp 5, frac 13; out_valid at cycle 6; out_id 0.
- Rounding carry and saturation:
  - D = 125 -> exp 4, frac 8.
  - D = 2047 -> exp 7, frac 15.
  - D = -2048 (0x800) -> sign 1, exp 7, frac 15.
  - D = 46 -> exp 2, frac 12.
- Small values and latency: D = -1 -> sign 1, exp 0, frac 1, out_valid at cycle 11; D = 0 -> all-zero result.
- All 4 requesters valid continuously, data = id + 1024:
  - Grants and out_id run 0,1,2,3,0,…; no requester is granted twice before every other valid requester has been granted once.
  - req_ready is one-hot per accept.
- Backpressure: hold out_ready = 0 for 5 cycles in RESP -> out_* stable, no new req_ready; release -> IDLE on the next cycle, then the next grant.
- Reset mid-NORM (D = 3, assert rst_n = 0 during the 3rd NORM cycle):
  - Next cycle: out_valid 0, busy 0, state IDLE.
  - After release, requester 0 is granted first and no stale result is emitted.

Source files
------------

// File: rtl/fpcvt_sched.sv
// Round-robin arbiter in front of one shared, multi-cycle 12-bit two's-complement
// to {sign, exp[2:0], frac[3:0]} converter; the result value is frac * 2^exp.
module fpcvt_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [12*N_REQ-1:0] req_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_W-1:0]     out_id,
  output logic                out_sign,
  output logic [2:0]          out_exp,
  output logic [3:0]          out_frac,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [11:0]     data_q, data_d;
  logic            sign_q, sign_d;
  logic [10:0]     m_q, m_d;
  logic [2:0]      e_q, e_d;
  logic            out_valid_q, out_valid_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            out_sign_q, out_sign_d;
  logic [2:0]      out_exp_q, out_exp_d;
  logic [3:0]      out_frac_q, out_frac_d;
  logic            busy_q, busy_d;

  logic            gnt_found_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic [11:0]     gnt_data_s;
  logic [10:0]     mag_s;
  logic [4:0]      f_s;
  logic [3:0]      e4_s;

  // Round-robin search; k runs downward so the nearest requester above rr_ptr wins.
  always_comb begin
    logic hit_s;
    hit_s       = 1'b0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        hit_s       = req_valid[i] && (i == ((int'(rr_ptr_q) + k) % N_REQ));
        gnt_found_s = gnt_found_s | hit_s;
        gnt_idx_s   = hit_s ? ID_W'(i) : gnt_idx_s;
      end
    end
  end

  // Accept strobe and sample mux for the granted requester.
  always_comb begin
    logic sel_s;
    sel_s      = 1'b0;
    gnt_data_s = 12'd0;
    req_ready  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_s        = (gnt_idx_s == ID_W'(i));
      gnt_data_s   = sel_s ? req_data[12*i +: 12] : gnt_data_s;
      req_ready[i] = sel_s && gnt_found_s && rst_n && (state_q == IDLE);
    end
  end

  // Sequencer next-state and datapath.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    sign_d      = sign_q;
    m_d         = m_q;
    e_d         = e_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    mag_s       = 11'd0;
    f_s         = 5'd0;
    e4_s        = 4'd0;
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          state_d  = LOAD;
          id_d     = gnt_idx_s;
          data_d   = gnt_data_s;
          rr_ptr_d = gnt_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        sign_d = data_q[11];
        // -2048 has no positive 12-bit twin; clamp its magnitude to 2047.
        if (!data_q[11]) begin
          mag_s = data_q[10:0];
        end else if (data_q[10:0] == 11'd0) begin
          mag_s = 11'h7FF;
        end else begin
          mag_s = ~data_q[10:0] + 11'd1;
        end
        m_d     = mag_s;
        e_d     = 3'd7;
        state_d = NORM;
      end
      NORM: begin
        if ((e_q == 3'd0) || m_q[10]) begin
          state_d = ROUND;
        end else begin
          m_d = {m_q[9:0], 1'b0};
          e_d = e_q - 3'd1;
        end
      end
      ROUND: begin
        f_s  = {1'b0, m_q[10:7]} + {4'd0, m_q[6]};
        e4_s = {1'b0, e_q};
        e4_s = f_s[4] ? (e4_s + 4'd1) : e4_s;
        f_s  = f_s[4] ? 5'd8 : f_s;
        f_s  = e4_s[3] ? 5'd15 : f_s;
        e4_s = e4_s[3] ? 4'd7 : e4_s;
        out_sign_d  = sign_q;
        out_exp_d   = e4_s[2:0];
        out_frac_d  = f_s[3:0];
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      data_q      <= 12'd0;
      sign_q      <= 1'b0;
      m_q         <= 11'd0;
      e_q         <= 3'd0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= 3'd0;
      out_frac_q  <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      sign_q      <= sign_d;
      m_q         <= m_d;
      e_q         <= e_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Scoreboard bench for fpcvt_sched: accepted samples push expected results
// (from an arithmetic reference model or fixed values), a monitor pops and compares.
module tb_fpcvt_sched;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [12*N-1:0] req_data;
  logic            out_valid, out_ready, out_sign, busy;
  logic [IW-1:0]   out_id;
  logic [2:0]      out_exp;
  logic [3:0]      out_frac;

  fpcvt_sched #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int sign; int e; int f; int lat; int acc;} exp_t;

  exp_t        sb_q[$];
  exp_t        dir_q[$];
  int          checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int          last_gnt = N - 1;
  int          mode = 0;        // 0 hold until accepted, 1 random requesters, 2 always re-request
  bit          rnd_ready = 1'b0;
  bit          use_model = 1'b1;
  logic [N-1:0] acc_vec = '0;
  bit          prev_ov = 1'b0, hs_prev = 1'b0;
  logic [IW+7:0] held;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Result = round-half-up(|D| / 2^e) with e chosen so the significand has 4 bits.
  function automatic exp_t model(input logic [11:0] d, input int id);
    exp_t r;
    int v, mag, p, e, f;
    v = d[11] ? int'(d) - 4096 : int'(d);
    r.sign = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    p = -1;
    for (int b = 0; b < 12; b++) if (mag >= (1 << b)) p = b;
    e = (p > 3) ? p - 3 : 0;
    f = (e == 0) ? mag : (mag + (1 << (e - 1))) >> e;
    if (f == 16) begin f = 8; e = e + 1; end
    if (e > 7) begin e = 7; f = 15; end
    r.e = e; r.f = f; r.id = id; r.acc = 0;
    r.lat = 3 + ((p <= 3) ? 8 : 11 - p);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: grant order, scoreboard comparison, latency, hold stability, bubble.
  initial begin
    exp_t ent;
    int g, idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_vec = '0; prev_ov = 1'b0; hs_prev = 1'b0;
      end else begin
        acc_vec = req_ready & req_valid;
        if (busy && (req_valid != '0)) chk("no_ready_when_busy", int'(req_ready), 0);
        if (acc_vec != '0) begin
          g = -1;
          for (int k = 1; k <= N; k++) begin
            idx = (last_gnt + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
          end
          chk("rr_grant", int'(acc_vec), 1 << g);
          last_gnt = g;
          if (use_model) begin
            ent = model(req_data[12*g +: 12], g);
          end else if (dir_q.size() > 0) begin
            ent = dir_q.pop_front();
          end else begin
            ent = model(req_data[12*g +: 12], g);
            chk("directed_entry_present", 0, 1);
          end
          ent.acc = cyc;
          sb_q.push_back(ent);
        end
        if (hs_prev) begin
          chk("bubble_valid_low", int'(out_valid), 0);
          chk("bubble_busy_low", int'(busy), 0);
          if (req_valid != '0) chk("bubble_grant", int'(req_ready != '0), 1);
        end
        if (out_valid && !prev_ov) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            ent = sb_q.pop_front();
            chk("out_id", int'(out_id), ent.id);
            chk("out_sign", int'(out_sign), ent.sign);
            chk("out_exp", int'(out_exp), ent.e);
            chk("out_frac", int'(out_frac), ent.f);
            chk("latency", cyc - ent.acc, ent.lat);
          end
          held = {out_id, out_sign, out_exp, out_frac};
        end else if (out_valid) begin
          chk("hold_stable", int'({out_id, out_sign, out_exp, out_frac}), int'(held));
        end
        if (out_valid && out_ready) done_cnt++;
        hs_prev = out_valid && out_ready;
        prev_ov = out_valid;
      end
    end
  end

  task automatic step();
    logic [11:0] d;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_vec[i] && mode != 2) req_valid[i] = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 2) == 0) d = 12'($urandom_range(0, 63)) - 12'd32;
          else d = 12'($urandom);
          req_data[12*i +: 12] = d;
          req_valid[i] = 1'b1;
        end
      end
    end
    if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic wait_done(input int tgt);
    for (int t = 0; t < 600 && done_cnt < tgt; t++) step();
    chk("done_count", done_cnt, tgt);
  endtask

  task automatic drain();
    for (int t = 0; t < 600 && (sb_q.size() > 0 || req_valid != '0 || out_valid); t++) step();
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step(); step();
    sb_q.delete();
    dir_q.delete();
    last_gnt = N - 1;
    rst_n = 1'b1;
  endtask

  task automatic run_one(input int id, input logic [11:0] d, input int s, input int e,
                         input int f, input int lat);
    exp_t ent;
    int base;
    ent.id = id; ent.sign = s; ent.e = e; ent.f = f; ent.lat = lat; ent.acc = 0;
    dir_q.push_back(ent);
    base = done_cnt;
    req_data[12*id +: 12] = d;
    req_valid[id] = 1'b1;
    out_ready = 1'b1;
    wait_done(base + 1);
  endtask

  initial begin
    exp_t ent;
    int base;
    bit r1, got;
    rst_n = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b1;
    req_valid[0] = 1'b1; req_data[11:0] = 12'd5;
    repeat (3) step();
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_fields", int'({out_id, out_sign, out_exp, out_frac}), 0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    use_model = 1'b0;
    run_one(0, 12'h1A6, 0, 5, 13, 6);
    run_one(1, 12'd125, 0, 4, 8, 8);
    run_one(2, 12'h7FF, 0, 7, 15, 4);
    run_one(3, 12'h800, 1, 7, 15, 4);
    run_one(0, 12'd46,  0, 2, 12, 9);
    run_one(1, 12'hFFF, 1, 0, 1, 11);
    run_one(2, 12'd0,   0, 0, 0, 11);

    // Backpressure: hold the first result 5 cycles while requester 1 waits.
    base = done_cnt;
    ent.id = 0; ent.sign = 0; ent.e = 5; ent.f = 13; ent.lat = 6; ent.acc = 0;
    dir_q.push_back(ent);
    ent.id = 1; ent.sign = 0; ent.e = 4; ent.f = 8; ent.lat = 8;
    dir_q.push_back(ent);
    req_data[11:0] = 12'h1A6; req_valid[0] = 1'b1; out_ready = 1'b0; r1 = 1'b0;
    for (int t = 0; t < 30 && !out_valid; t++) begin
      step();
      if (!req_valid[0] && !r1) begin
        req_data[23:12] = 12'd125; req_valid[1] = 1'b1; r1 = 1'b1;
      end
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    repeat (5) step();
    out_ready = 1'b1;
    wait_done(base + 2);

    // Reset during the third NORM cycle of D = 3.
    use_model = 1'b1;
    req_data[11:0] = 12'd3; req_valid[0] = 1'b1; got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      if (!req_valid[0]) got = 1'b1;
    end
    chk("rst_test_accepted", int'(got), 1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midnorm_rst_valid", int'(out_valid), 0);
    chk("midnorm_rst_busy", int'(busy), 0);
    sb_q.delete();
    last_gnt = N - 1;
    req_data[11:0] = 12'd3; req_data[35:24] = 12'hED4;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    base = done_cnt;
    rst_n = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      step();
      if (acc_vec != '0) begin
        chk("first_grant_after_reset", int'(acc_vec), 1);
        got = 1'b1;
      end
    end
    wait_done(base + 2);

    // All four requesters continuously valid.
    do_reset();
    mode = 2;
    for (int i = 0; i < N; i++) req_data[12*i +: 12] = 12'(1024 + i);
    req_valid = '1;
    base = done_cnt;
    wait_done(base + 12);
    mode = 0;
    req_valid = '0;
    drain();

    // Randomised requesters and consumer.
    mode = 1; rnd_ready = 1'b1;
    repeat (3000) step();
    mode = 0; rnd_ready = 1'b0; out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
